// File: rtl/mips_stage_sequencer.sv
// Multicycle stage controller: issues one-cycle IF/ID/EX/MEM/WB enables,
// paced by a free-running tick divider or a debounced single-step key.
`timescale 1ns/1ps
module mips_stage_sequencer #(
    parameter int TICK_PERIOD = 33554432,
    parameter int DEB_CYCLES  = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic        en_if,
    output logic        en_id,
    output logic        en_ex,
    output logic        en_mem,
    output logic        en_wb,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count
);
    localparam int TW = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd7
    } stage_t;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_ALU    = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4
    } class_t;

    logic [TW-1:0] tick_cnt_reg;
    logic          tick_r;
    logic [1:0]    sync_reg;
    logic          deb_level_reg;
    logic          deb_prev_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic          step_r;
    stage_t        stage_reg;
    class_t        class_reg;
    class_t        class_dec;
    logic          halt_pending_reg;
    logic          halt_now;
    logic          is_final;
    logic          advance;
    logic          en_if_reg, en_id_reg, en_ex_reg, en_mem_reg, en_wb_reg;
    logic          halted_reg, illegal_reg;
    logic [31:0]   instr_count_reg;

    // Tick divider runs regardless of mode so switching modes keeps its phase.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt_reg <= '0;
            tick_r       <= 1'b0;
        end else if (tick_cnt_reg == TW'(TICK_PERIOD - 1)) begin
            tick_cnt_reg <= '0;
            tick_r       <= 1'b1;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
            tick_r       <= 1'b0;
        end
    end

    // Key path: synchronizer, stability-count debouncer, falling-edge detect.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_reg      <= 2'b11;
            deb_level_reg <= 1'b1;
            deb_prev_reg  <= 1'b1;
            deb_cnt_reg   <= '0;
            step_r        <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], step_btn};
            if (sync_reg[1] != deb_level_reg) begin
                if (deb_cnt_reg == DW'(DEB_CYCLES - 1)) begin
                    deb_level_reg <= sync_reg[1];
                    deb_cnt_reg   <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + DW'(1);
                end
            end else begin
                deb_cnt_reg <= '0;
            end
            deb_prev_reg <= deb_level_reg;
            step_r       <= deb_prev_reg & ~deb_level_reg;
        end
    end

    always_comb begin
        class_dec = CL_NONE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                    6'h27, 6'h2A, 6'h00, 6'h02: class_dec = CL_ALU;
                    default:                    class_dec = CL_NONE;
                endcase
            end
            6'h08, 6'h0C, 6'h0D, 6'h0A: class_dec = CL_ALU;
            6'h23:                      class_dec = CL_LOAD;
            6'h2B:                      class_dec = CL_STORE;
            6'h04, 6'h05, 6'h02:        class_dec = CL_BRANCH;
            default:                    class_dec = CL_NONE;
        endcase
    end

    assign advance  = run_mode ? tick_r : step_r;
    assign halt_now = halt_pending_reg | halt_req;
    assign is_final = (stage_reg == ST_WB)
                   || (stage_reg == ST_EX  && class_reg == CL_BRANCH)
                   || (stage_reg == ST_MEM && class_reg == CL_STORE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stage_reg        <= ST_IF;
            class_reg        <= CL_NONE;
            halt_pending_reg <= 1'b0;
            en_if_reg        <= 1'b0;
            en_id_reg        <= 1'b0;
            en_ex_reg        <= 1'b0;
            en_mem_reg       <= 1'b0;
            en_wb_reg        <= 1'b0;
            halted_reg       <= 1'b0;
            illegal_reg      <= 1'b0;
            instr_count_reg  <= '0;
        end else begin
            en_if_reg  <= 1'b0;
            en_id_reg  <= 1'b0;
            en_ex_reg  <= 1'b0;
            en_mem_reg <= 1'b0;
            en_wb_reg  <= 1'b0;
            if (halt_req) halt_pending_reg <= 1'b1;
            if (advance && stage_reg != ST_HALT) begin
                case (stage_reg)
                    ST_IF: begin
                        if (halt_now) begin
                            stage_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            en_if_reg <= 1'b1;
                            stage_reg <= ST_ID;
                        end
                    end
                    ST_ID: begin
                        en_id_reg <= 1'b1;
                        class_reg <= class_dec;
                        if (class_dec == CL_NONE) begin
                            illegal_reg <= 1'b1;
                            halted_reg  <= 1'b1;
                            stage_reg   <= ST_HALT;
                        end else begin
                            stage_reg <= ST_EX;
                        end
                    end
                    ST_EX: begin
                        en_ex_reg <= 1'b1;
                        stage_reg <= (class_reg == CL_ALU) ? ST_WB : ST_MEM;
                    end
                    ST_MEM: begin
                        en_mem_reg <= 1'b1;
                        stage_reg  <= ST_WB;
                    end
                    ST_WB:   en_wb_reg <= 1'b1;
                    default: stage_reg <= ST_IF;
                endcase
                // Retire overrides the successor chosen above.
                if (is_final) begin
                    instr_count_reg <= instr_count_reg + 32'd1;
                    stage_reg       <= halt_now ? ST_HALT : ST_IF;
                    halted_reg      <= halt_now;
                end
            end
        end
    end

    assign en_if       = en_if_reg;
    assign en_id       = en_id_reg;
    assign en_ex       = en_ex_reg;
    assign en_mem      = en_mem_reg;
    assign en_wb       = en_wb_reg;
    assign stage       = stage_reg;
    assign halted      = halted_reg;
    assign illegal     = illegal_reg;
    assign instr_count = instr_count_reg;
endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Scoreboard bench: expected stage pulses are queued by the stimulus and
// matched by a monitor whenever the sequencer raises any enable.
`timescale 1ns/1ps
module tb_mips_stage_sequencer;
    localparam logic [4:0] P_IF  = 5'b10000;
    localparam logic [4:0] P_ID  = 5'b01000;
    localparam logic [4:0] P_EX  = 5'b00100;
    localparam logic [4:0] P_MEM = 5'b00010;
    localparam logic [4:0] P_WB  = 5'b00001;

    typedef struct {
        logic [4:0]  en;
        int          cyc;
        logic [31:0] cnt;
        logic [2:0]  stg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_mode = 1'b1;
    logic        step_btn = 1'b1;
    logic        halt_req = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h20;
    logic        en_if, en_id, en_ex, en_mem, en_wb;
    logic [2:0]  stage;
    logic        halted, illegal;
    logic [31:0] instr_count;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    mips_stage_sequencer #(.TICK_PERIOD(4), .DEB_CYCLES(3)) dut (
        .CLOCK_50(clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn),
        .halt_req(halt_req), .opcode(opcode), .funct(funct),
        .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
        .stage(stage), .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Cycle index: 0 at the reset edge, n at the n-th edge after release.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [4:0] en, input int c, input logic [31:0] cnt, input logic [2:0] stg);
        exp_t e;
        e.en = en; e.cyc = c; e.cnt = cnt; e.stg = stg;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input logic mode, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        reset = 1'b1; run_mode = mode; opcode = op; funct = fn;
        step_btn = 1'b1; halt_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("reset_stage", 32'(stage), 32'd1);
        check("reset_en", 32'({en_if, en_id, en_ex, en_mem, en_wb}), 32'd0);
        check("reset_flags", 32'({halted, illegal}), 32'd0);
        check("reset_count", instr_count, 32'd0);
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every enable pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [4:0] en_v;
        exp_t e;
        en_v = {en_if, en_id, en_ex, en_mem, en_wb};
        if (!reset && en_v != 5'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got en=%b stage=%0d at cycle %0d, expected no pulse",
                         en_v, stage, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_en", 32'(en_v), 32'(e.en));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_count", instr_count, e.cnt);
                check("pulse_stage", 32'(stage), 32'(e.stg));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        // add: IF ID EX WB, no MEM
        do_reset(1'b1, 6'h00, 6'h20);
        push(P_IF, 5, 0, 2); push(P_ID, 9, 0, 3); push(P_EX, 13, 0, 5); push(P_WB, 17, 1, 1);
        wait_until(19);
        check_drained("add_drained");

        // lw then sw back to back
        do_reset(1'b1, 6'h23, 6'h00);
        push(P_IF, 5, 0, 2); push(P_ID, 9, 0, 3); push(P_EX, 13, 0, 4);
        push(P_MEM, 17, 0, 5); push(P_WB, 21, 1, 1);
        push(P_IF, 25, 1, 2); push(P_ID, 29, 1, 3); push(P_EX, 33, 1, 4); push(P_MEM, 37, 2, 1);
        wait_until(23);
        opcode = 6'h2B;
        wait_until(39);
        check("ldst_count", instr_count, 32'd2);
        check_drained("ldst_drained");

        // beq retires on EX, then an illegal opcode halts after ID
        do_reset(1'b1, 6'h04, 6'h00);
        push(P_IF, 5, 0, 2); push(P_ID, 9, 0, 3); push(P_EX, 13, 1, 1);
        push(P_IF, 17, 1, 2); push(P_ID, 21, 1, 7);
        wait_until(18);
        opcode = 6'h3F;
        wait_until(62);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_halted", 32'(halted), 32'd1);
        check("illegal_stage", 32'(stage), 32'd7);
        check("illegal_count", instr_count, 32'd1);
        check_drained("illegal_drained");

        // halt_req during EX: WB still issued, then HALT with no IF
        do_reset(1'b1, 6'h00, 6'h20);
        push(P_IF, 5, 0, 2); push(P_ID, 9, 0, 3); push(P_EX, 13, 0, 5); push(P_WB, 17, 1, 7);
        wait_until(14);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        wait_until(40);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_stage", 32'(stage), 32'd7);
        check("halt_count", instr_count, 32'd1);
        check_drained("halt_drained");

        // reset during ID on the same edge as a tick advance: no en_id
        do_reset(1'b1, 6'h00, 6'h20);
        push(P_IF, 5, 0, 2);
        wait_until(8);
        check("pre_reset_stage", 32'(stage), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_stage", 32'(stage), 32'd1);
        check("midreset_en", 32'({en_if, en_id, en_ex, en_mem, en_wb}), 32'd0);
        check("midreset_count", instr_count, 32'd0);
        check("midreset_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        check_drained("midreset_drained");

        // step mode: short press, clean press, press with release bounce
        do_reset(1'b0, 6'h00, 6'h20);
        wait_until(3);
        step_btn = 1'b0;
        repeat (2) @(negedge clk);
        step_btn = 1'b1;
        wait_until(20);
        n = cyc;
        step_btn = 1'b0;
        push(P_IF, n + 7, 0, 2);
        repeat (20) @(negedge clk);
        step_btn = 1'b1;
        repeat (20) @(negedge clk);
        n = cyc;
        step_btn = 1'b0;
        push(P_ID, n + 7, 0, 3);
        repeat (20) @(negedge clk);
        step_btn = 1'b1;
        @(negedge clk);
        step_btn = 1'b0;
        repeat (2) @(negedge clk);
        step_btn = 1'b1;
        repeat (30) @(negedge clk);
        check("step_stage", 32'(stage), 32'd3);
        check("step_halted", 32'(halted), 32'd0);
        check_drained("step_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
